// File: rtl/y_mc_if.sv
// y_mc_if: control/status bundle between y_mc_ctrl and the yIF/yID/yEX/yDM/yWB datapath.
// run is a single-cycle start pulse, only honoured while the sequencer idles; there is no ready/valid back-pressure.
interface y_mc_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             run;
    logic [XLEN-1:0]  ins;
    logic             zero;
    logic [XLEN-1:0]  pc_p4;
    logic [XLEN-1:0]  branch;
    logic [XLEN-1:0]  jTarget;
    logic [XLEN-1:0]  PCin;
    logic             RegWrite;
    logic             ALUSrc;
    logic [2:0]       op;
    logic             MemRead;
    logic             MemWrite;
    logic             Mem2Reg;
    logic             Link;
    logic             halt;
    logic             illegal;
    logic [CNT_W-1:0] icount;
    logic [2:0]       dbg_state;

    modport master (
        input  run, ins, zero, pc_p4, branch, jTarget,
        output PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, Link,
               halt, illegal, icount, dbg_state
    );

    modport slave (
        output run, ins, zero, pc_p4, branch, jTarget,
        input  PCin, RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, Link,
               halt, illegal, icount, dbg_state
    );
endinterface

// File: rtl/y_mc_ctrl.sv
// y_mc_ctrl: multi-cycle FETCH..WB sequencer owning the PC and retired-instruction count.
// Define YCTRL_BRANCH_EN to make beq (63h) a real branch; otherwise it runs as a 3-cycle NOP.
module y_mc_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h28),
    parameter int              CNT_W    = 16,
    parameter int              MAX_INS  = 0
) (
    input logic    clk,
    input logic    rst_n,
    y_mc_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
        S_EXEC = 3'd3, S_MEM   = 3'd4, S_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_LOAD, K_STORE, K_BEQ, K_JAL, K_NOP, K_ILL
    } kind_t;

    state_t           state, state_n;
    kind_t            dec_kind, kind_q;
    logic             dec_alusrc, alusrc_q;
    logic [2:0]       dec_op, op_q;
    logic [XLEN-1:0]  pc, pc_n;
    logic [CNT_W-1:0] icount, icount_n;
    logic             halt, halt_hit, retire;
    logic             unused_ins;

    assign unused_ins = ^{bus.ins[24:15], bus.ins[11:7]};

    function automatic logic [2:0] alu_op(input logic [2:0] f3);
        case (f3)
            3'b111:  alu_op = 3'b000;
            3'b110:  alu_op = 3'b001;
            3'b010:  alu_op = 3'b111;
            default: alu_op = 3'b010;
        endcase
    endfunction

    always_comb begin
        dec_kind   = K_ILL;
        dec_alusrc = 1'b0;
        dec_op     = 3'b000;
        case (bus.ins[6:0])
            7'h33: begin
                dec_kind = K_ALU;
                dec_op   = (bus.ins[14:12] == 3'b000 && bus.ins[31:25] == 7'h20)
                         ? 3'b110 : alu_op(bus.ins[14:12]);
            end
            7'h13: begin
                dec_kind   = K_ALU;
                dec_alusrc = 1'b1;
                dec_op     = alu_op(bus.ins[14:12]);
            end
            7'h03: begin
                dec_kind   = K_LOAD;
                dec_alusrc = 1'b1;
                dec_op     = 3'b010;
            end
            7'h23: begin
                dec_kind   = K_STORE;
                dec_alusrc = 1'b1;
                dec_op     = 3'b010;
            end
            7'h63: begin
`ifdef YCTRL_BRANCH_EN
                dec_kind = K_BEQ;
                dec_op   = 3'b110;
`else
                dec_kind = K_NOP;
`endif
            end
            7'h6F:   dec_kind = K_JAL;
            default: dec_kind = K_ILL;
        endcase
    end

    // Controls come from state plus the decode latched on leaving DECODE.
    always_comb begin
        state_n      = state;
        retire       = 1'b0;
        halt_hit     = 1'b0;
        pc_n         = bus.pc_p4;
        icount_n     = icount;
        bus.RegWrite = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.op       = 3'b000;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Mem2Reg  = 1'b0;
        bus.Link     = 1'b0;
        bus.illegal  = 1'b0;
        case (state)
            S_IDLE:  if (bus.run && !halt) state_n = S_FETCH;
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                if (dec_kind == K_ILL) begin
                    bus.illegal = 1'b1;
                    retire      = 1'b1;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.ALUSrc = alusrc_q;
                bus.op     = op_q;
                case (kind_q)
                    K_LOAD, K_STORE: state_n = S_MEM;
                    K_BEQ, K_NOP:    retire  = 1'b1;
                    default:         state_n = S_WB;
                endcase
                if (kind_q == K_BEQ && bus.zero) pc_n = bus.branch;
            end
            S_MEM: begin
                bus.ALUSrc   = alusrc_q;
                bus.op       = op_q;
                bus.MemRead  = (kind_q == K_LOAD);
                bus.MemWrite = (kind_q == K_STORE);
                if (kind_q == K_STORE) retire = 1'b1;
                else                   state_n = S_WB;
            end
            S_WB: begin
                bus.ALUSrc   = alusrc_q;
                bus.op       = op_q;
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = (kind_q == K_LOAD);
                bus.Link     = (kind_q == K_JAL);
                retire       = 1'b1;
                if (kind_q == K_JAL) pc_n = bus.jTarget;
            end
            default: state_n = S_IDLE;
        endcase
        if (retire) begin
            icount_n = (&icount) ? icount : icount + CNT_W'(1);
            halt_hit = (MAX_INS != 0) && (icount_n == CNT_W'(MAX_INS));
            state_n  = halt_hit ? S_IDLE : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            icount   <= '0;
            halt     <= 1'b0;
            kind_q   <= K_NOP;
            alusrc_q <= 1'b0;
            op_q     <= 3'b000;
        end else begin
            state  <= state_n;
            icount <= icount_n;
            if (state == S_IDLE && state_n == S_FETCH) pc <= RESET_PC;
            else if (retire)                           pc <= pc_n;
            if (halt_hit) halt <= 1'b1;
            if (state == S_DECODE) begin
                kind_q   <= dec_kind;
                alusrc_q <= dec_alusrc;
                op_q     <= dec_op;
            end
        end
    end

    assign bus.PCin      = pc;
    assign bus.halt      = halt;
    assign bus.icount    = icount;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_y_mc_ctrl.sv
// tb_y_mc_ctrl: directed instruction sequences against y_mc_ctrl (MAX_INS=11).
// Expected per-cycle control vectors are queued by the driver and checked by a negedge monitor.
module tb_y_mc_ctrl;
    localparam int XLEN    = 32;
    localparam int CNT_W   = 16;
    localparam int MAX_INS = 11;
    localparam int VW      = 62;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5;
    localparam int KR = 0, KL = 1, KS = 2, KB = 3, KJ = 4, KX = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    y_mc_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();

    y_mc_ctrl #(.XLEN(XLEN), .RESET_PC(32'h28), .CNT_W(CNT_W), .MAX_INS(MAX_INS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // yIF model: PC+4 of whatever PC the sequencer presents
    assign bus.pc_p4 = bus.PCin + 32'd4;

    logic [VW-1:0] exp_q[$];
    string         name_q[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [31:0]   m_pc;
    logic [15:0]   m_cnt;
    logic          m_halt;
    logic [VW-1:0] obs;

    assign obs = {bus.dbg_state, bus.RegWrite, bus.ALUSrc, bus.op, bus.MemRead, bus.MemWrite,
                  bus.Mem2Reg, bus.Link, bus.illegal, bus.halt, bus.PCin, bus.icount};

    // ctl = {RegWrite, ALUSrc, op[2:0], MemRead, MemWrite, Mem2Reg, Link, illegal}
    function automatic logic [VW-1:0] vec(input logic [2:0] st, input logic [9:0] ctl,
                                          input logic hl, input logic [31:0] pc,
                                          input logic [15:0] cnt);
        return {st, ctl, hl, pc, cnt};
    endfunction

    task automatic push(input string nm, input logic [VW-1:0] v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic cmp(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (bus.dbg_state != ST_IDLE) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_activity: got %h required idle", obs);
            end else begin
                logic [VW-1:0] e;
                string         nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, obs, e);
            end
        end
    end

    task automatic check_idle(input string nm);
        cmp(nm, obs, vec(ST_IDLE, 10'b0, m_halt, m_pc, m_cnt));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_pc   = 32'h28;
        m_cnt  = 16'd0;
        m_halt = 1'b0;
    endtask

    task automatic start_run();
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        bus.run = 1'b0;
        m_pc    = 32'h28;
        n_vec++;
        if (bus.dbg_state !== ST_FETCH) begin
            n_bad++;
            $display("FAIL run_start: state %0d required %0d", bus.dbg_state, ST_FETCH);
        end
    endtask

    task automatic wait_boundary(input string nm);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.dbg_state != ST_FETCH && bus.dbg_state != ST_IDLE && n < 12);
        n_vec++;
        if (n >= 12) begin
            n_bad++;
            $display("FAIL %s_timeout: state %0d after %0d cycles", nm, bus.dbg_state, n);
        end
    endtask

    // Called with the DUT sitting in FETCH, 1 time unit after the edge.
    task automatic do_instr(input string nm, input logic [31:0] i, input int kind,
                            input logic as, input logic [2:0] op, input logic z,
                            input logic [31:0] br, input logic [31:0] jt);
        logic [31:0] npc;
        bus.ins     = i;
        bus.zero    = z;
        bus.branch  = br;
        bus.jTarget = jt;
        npc = m_pc + 32'd4;
`ifndef YCTRL_BRANCH_EN
        if (kind == KB) begin
            as = 1'b0;
            op = 3'b000;
        end
`endif
        push({nm, "_fetch"},  vec(ST_FETCH, 10'b0, 1'b0, m_pc, m_cnt));
        push({nm, "_decode"}, vec(ST_DECODE, {9'b0, kind == KX}, 1'b0, m_pc, m_cnt));
        if (kind != KX)
            push({nm, "_exec"}, vec(ST_EXEC, {1'b0, as, op, 5'b0}, 1'b0, m_pc, m_cnt));
        case (kind)
            KL: begin
                push({nm, "_mem"}, vec(ST_MEM, {1'b0, as, op, 5'b10000}, 1'b0, m_pc, m_cnt));
                push({nm, "_wb"},  vec(ST_WB,  {1'b1, as, op, 5'b00100}, 1'b0, m_pc, m_cnt));
            end
            KS: push({nm, "_mem"}, vec(ST_MEM, {1'b0, as, op, 5'b01000}, 1'b0, m_pc, m_cnt));
            KR: push({nm, "_wb"},  vec(ST_WB,  {1'b1, as, op, 5'b00000}, 1'b0, m_pc, m_cnt));
            KJ: begin
                push({nm, "_wb"}, vec(ST_WB, {1'b1, as, op, 5'b00010}, 1'b0, m_pc, m_cnt));
                npc = jt;
            end
            KB: begin
`ifdef YCTRL_BRANCH_EN
                if (z) npc = br;
`endif
            end
            default: ;
        endcase
        m_pc  = npc;
        m_cnt = m_cnt + 16'd1;
        if (m_cnt == 16'(MAX_INS)) m_halt = 1'b1;
        wait_boundary(nm);
    endtask

    task automatic end_prog(input string nm);
        push({nm, "_fetch"}, vec(ST_FETCH, 10'b0, 1'b0, m_pc, m_cnt));
        apply_reset();
    endtask

    initial begin
        bus.run     = 1'b0;
        bus.ins     = 32'h0;
        bus.zero    = 1'b0;
        bus.branch  = 32'h0;
        bus.jTarget = 32'h0;
        m_pc   = 32'h28;
        m_cnt  = 16'd0;
        m_halt = 1'b0;
        apply_reset();
        check_idle("reset");

        start_run();
        do_instr("add",     32'h00A30333, KR, 1'b0, 3'b010, 1'b0, 32'h0, 32'h0);
        do_instr("sub",     32'h40A30333, KR, 1'b0, 3'b110, 1'b0, 32'h0, 32'h0);
        do_instr("and",     32'h00A37333, KR, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
        do_instr("or",      32'h00A36333, KR, 1'b0, 3'b001, 1'b0, 32'h0, 32'h0);
        do_instr("slt",     32'h00A32333, KR, 1'b0, 3'b111, 1'b0, 32'h0, 32'h0);
        do_instr("addi",    32'h00A30313, KR, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        do_instr("addi_f7", 32'h40A30313, KR, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        do_instr("ori",     32'h00A36313, KR, 1'b1, 3'b001, 1'b0, 32'h0, 32'h0);
        do_instr("lw",      32'h0002A303, KL, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        do_instr("sw",      32'h0062A023, KS, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        end_prog("p1_end");
        check_idle("p1_reset");

        start_run();
        do_instr("beq_taken", 32'h00628463, KB, 1'b0, 3'b110, 1'b1, 32'h40, 32'h0);
        do_instr("beq_not",   32'h00628463, KB, 1'b0, 3'b110, 1'b0, 32'h80, 32'h0);
        do_instr("jal",       32'h0100006F, KJ, 1'b0, 3'b000, 1'b0, 32'h0,  32'h50);
        do_instr("ill_ff",    32'hFFFFFFFF, KX, 1'b0, 3'b000, 1'b0, 32'h0,  32'h0);
        do_instr("ill_00",    32'h00000000, KX, 1'b0, 3'b000, 1'b0, 32'h0,  32'h0);
        end_prog("p2_end");

        start_run();
        for (int k = 0; k < MAX_INS; k++)
            do_instr("halt_addi", 32'h00A30313, KR, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        check_idle("halt_state");
        bus.run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.run = 1'b0;
        check_idle("halt_ignores_run");
        apply_reset();
        check_idle("reset_clears_halt");

        start_run();
        do_instr("pre_abort_a", 32'h00A30313, KR, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        do_instr("pre_abort_b", 32'h00A30313, KR, 1'b1, 3'b010, 1'b0, 32'h0, 32'h0);
        bus.ins = 32'h0062A023;
        push("abort_fetch",  vec(ST_FETCH,  10'b0, 1'b0, m_pc, m_cnt));
        push("abort_decode", vec(ST_DECODE, 10'b0, 1'b0, m_pc, m_cnt));
        push("abort_exec",   vec(ST_EXEC, {1'b0, 1'b1, 3'b010, 5'b0}, 1'b0, m_pc, m_cnt));
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        check_idle("reset_mid_exec");
        repeat (3) @(posedge clk);
        #1;
        check_idle("idle_after_abort");

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expected: got %0d entries required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
